rv32i_hazard_unit: RTL and testbench
====================================

// Module: rv32i_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the RV32I 5-stage pipeline. It replaces the fixed
//  three-source forwarding in the ID stage with FWD_STAGES generic sources, in priority order.
//  It adds load-use stall, data-memory wait freeze with watchdog, jump-flush gating and perf counters.
//  It sits beside rv32i_idTop: regfile reads in, forwarded operands and pipeline stall/flush controls out.
// PARAMETERS
//  XLEN         32  datapath width
//  REG_W        5   register index width (x0 hard-wired zero)
//  FWD_STAGES   3   forwarding sources; index 0 = EX (nearest), FWD_STAGES-1 = WB (farthest)
//  MEM_TIMEOUT  16  MEM_WAIT cycles before mem_err is raised (>=1)
//  CNT_W        32  width of perf counters
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   asynchronous, active-high reset
//  rs1_reg      in   REG_W               ID source reg 1 index
//  rs2_reg      in   REG_W               ID source reg 2 index
//  rs1_used     in   1                   ID instruction reads rs1
//  rs2_used     in   1                   ID instruction reads rs2
//  rs1_data_in  in   XLEN                regfile read data 1
//  rs2_data_in  in   XLEN                regfile read data 2
//  fwd_enable   in   FWD_STAGES          per-stage writeback enable
//  fwd_reg      in   FWD_STAGES*REG_W    per-stage destination reg, packed, stage 0 in LSBs
//  fwd_data     in   FWD_STAGES*XLEN     per-stage result, packed
//  fwd_pending  in   FWD_STAGES          per-stage result not yet valid (load in flight)
//  jump_enable  in   1                   jump resolved in ID this cycle
//  mem_req      in   1                   MEM stage has a load/store this cycle
//  mem_ready    in   1                   data memory accepts/returns this cycle
//  rs1_data_out out  XLEN                forwarded operand 1
//  rs2_data_out out  XLEN                forwarded operand 2
//  stall_id     out  1                   hold PC and IF/ID register
//  bubble_ex    out  1                   insert NOP into ID/EX
//  freeze       out  1                   hold every pipeline register
//  flush_if     out  1                   squash instruction in IF/ID (jump taken)
//  state        out  2                   FSM state: RUN=0, LD_STALL=1, MEM_WAIT=2
//  mem_err      out  1                   sticky watchdog error
//  stall_count  out  CNT_W               cycles with stall_id|freeze
//  flush_count  out  CNT_W               cycles with flush_if
// BEHAVIOUR
//  - Forwarding (comb.): for each rsN, choose the lowest stage i with fwd_enable[i] and fwd_reg[i]==rsN.
//    If rsN==0, output 0 regardless of any match. With no match, output rsN_data_in.
//  - Load-use: hit_ld = rsN_used and the winning match i has fwd_pending[i]. A farther non-pending match
//    never overrides a nearer pending one. stall_id=bubble_ex=hit_ld & ~freeze, combinational.
//  - Freeze (comb.): freeze = mem_req & ~mem_ready. Freeze overrides everything. stall_id=0, bubble_ex=0, flush_if=0.
//  - flush_if = jump_enable & ~stall_id & ~freeze. A jump seen during a stall is ignored; ID re-presents it.
//  - FSM, registered, evaluated every cycle:
//      next = MEM_WAIT if freeze; else LD_STALL if hit_ld; else RUN.
//  - Watchdog: wait_cnt increments each cycle in MEM_WAIT with freeze still high. It clears on leaving
//    MEM_WAIT. When wait_cnt==MEM_TIMEOUT-1 and freeze is still high, mem_err is set and held until reset.
//  - Counters: registered, +1 on the qualifying cycle, saturate at all-ones with no wrap.
//  - Reset (async, any time, incl. mid-MEM_WAIT): state=RUN, wait_cnt=0, mem_err=0, both counters=0.
//    Combinational outputs track inputs during reset.
//  - Latency: all control and data outputs are 0-cycle combinational from inputs. Only state, mem_err
//    and the counters are registered, with 1-cycle update.
// STRUCTURE
//  - rv32i_pkg holds: hz_state_t enum {HZ_RUN, HZ_LD_STALL, HZ_MEM_WAIT}, REG_ZERO constant.
//  - One sub-module, rv32i_fwd_mux (parametrised priority match/select), instantiated once per source operand.
//  - FSM, watchdog and counters live in this module.
// TESTING
//  1. No hazard: rs1=5, no fwd_enable, rs1_data_in=0x11 -> rs1_data_out=0x11, stall_id=0, state RUN.
//  2. Priority: stages 0 and 2 both write x7, data 0xA / 0xC, rs2=7 -> rs2_data_out=0xA.
//     Repeat with rs2=0 -> output 0.
//  3. Load-use: stage0 pending, writes x3, rs1=3 used -> stall_id=bubble_ex=1.
//     State goes LD_STALL next cycle, stall_count=1. Drop pending -> RUN.
//  4. Jump during stall: jump_enable=1 with hit_ld=1 -> flush_if=0.
//     Next cycle, no hazard -> flush_if=1, flush_count=1.
//  5. Memory wait/timeout: mem_req=1, mem_ready=0 for 16 cycles -> freeze=1 throughout, state MEM_WAIT.
//     mem_err=1 after the 16th cycle. Assert reset mid-wait -> state RUN, mem_err=0, counters 0.
//  6. Saturation (CNT_W=4): hold freeze 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared types and constants for the RV32I hazard/forwarding logic.
//   hz_state_t : hazard controller state (RUN=0, LD_STALL=1, MEM_WAIT=2)
//   REG_ZERO   : index of the hard-wired zero register x0
// ---------------------------------------------------------------------------
package rv32i_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LD_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32i_fwd_mux.sv
// ---------------------------------------------------------------------------
// rv32i_fwd_mux
//   Priority forwarding select for one source operand. The nearest stage
//   (lowest index) whose writeback targets rs_reg_i supplies the operand;
//   x0 always reads as zero and never creates a hazard.
// Ports:
//   rs_reg_i      source register index
//   rs_used_i     instruction actually reads this operand
//   rs_data_i     register file read data
//   fwd_enable_i  per-stage writeback enable
//   fwd_reg_i     per-stage destination index, stage 0 in LSBs
//   fwd_data_i    per-stage result, stage 0 in LSBs
//   fwd_pending_i per-stage result not yet available
//   rs_data_o     forwarded operand
//   hit_ld_o      operand is used and its winning source is still pending
// ---------------------------------------------------------------------------
module rv32i_fwd_mux
    import rv32i_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3
) (
    input  logic [REG_W-1:0]            rs_reg_i,
    input  logic                        rs_used_i,
    input  logic [XLEN-1:0]             rs_data_i,
    input  logic [FWD_STAGES-1:0]       fwd_enable_i,
    input  logic [FWD_STAGES*REG_W-1:0] fwd_reg_i,
    input  logic [FWD_STAGES*XLEN-1:0]  fwd_data_i,
    input  logic [FWD_STAGES-1:0]       fwd_pending_i,
    output logic [XLEN-1:0]             rs_data_o,
    output logic                        hit_ld_o
);

    logic            is_zero;
    logic            match_found;
    logic            match_pending;
    logic [XLEN-1:0] sel_data;

    assign is_zero = (rs_reg_i == REG_W'(REG_ZERO));

    // Scan from the farthest stage toward the nearest so that the last
    // assignment wins, giving the lowest matching index priority. A nearer
    // pending match therefore always hides a farther ready one.
    always_comb begin
        match_found   = 1'b0;
        match_pending = 1'b0;
        sel_data      = rs_data_i;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (fwd_enable_i[i] && (fwd_reg_i[i*REG_W +: REG_W] == rs_reg_i)) begin
                match_found   = 1'b1;
                match_pending = fwd_pending_i[i];
                sel_data      = fwd_data_i[i*XLEN +: XLEN];
            end
        end
    end

    assign rs_data_o = is_zero ? '0 : sel_data;
    assign hit_ld_o  = rs_used_i & ~is_zero & match_found & match_pending;

endmodule

// File: rtl/rv32i_hazard_unit.sv
// ---------------------------------------------------------------------------
// rv32i_hazard_unit
//   Hazard and forwarding controller beside the ID stage of the RV32I
//   5-stage pipeline: generic priority forwarding, load-use stall, data
//   memory wait freeze with a sticky watchdog, jump flush gating and
//   saturating stall/flush performance counters.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   rs1_reg/rs2_reg          ID source register indices
//   rs1_used/rs2_used        ID instruction reads the operand
//   rs1_data_in/rs2_data_in  register file read data
//   fwd_enable/fwd_reg/fwd_data/fwd_pending  per-stage forwarding sources
//   jump_enable              jump resolved in ID this cycle
//   mem_req/mem_ready        MEM stage access request / memory handshake
//   rs1_data_out/rs2_data_out forwarded operands (combinational)
//   stall_id/bubble_ex       load-use stall controls (combinational)
//   freeze                   hold all pipeline registers (combinational)
//   flush_if                 squash IF/ID on a taken jump (combinational)
//   state                    registered controller state
//   mem_err                  sticky memory watchdog error
//   stall_count/flush_count  saturating performance counters
// ---------------------------------------------------------------------------
module rv32i_hazard_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_W       = 5,
    parameter int FWD_STAGES  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REG_W-1:0]            rs1_reg,
    input  logic [REG_W-1:0]            rs2_reg,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    input  logic [XLEN-1:0]             rs1_data_in,
    input  logic [XLEN-1:0]             rs2_data_in,
    input  logic [FWD_STAGES-1:0]       fwd_enable,
    input  logic [FWD_STAGES*REG_W-1:0] fwd_reg,
    input  logic [FWD_STAGES*XLEN-1:0]  fwd_data,
    input  logic [FWD_STAGES-1:0]       fwd_pending,
    input  logic                        jump_enable,
    input  logic                        mem_req,
    input  logic                        mem_ready,
    output logic [XLEN-1:0]             rs1_data_out,
    output logic [XLEN-1:0]             rs2_data_out,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic                        freeze,
    output logic                        flush_if,
    output logic [1:0]                  state,
    output logic                        mem_err,
    output logic [CNT_W-1:0]            stall_count,
    output logic [CNT_W-1:0]            flush_count
);

    // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic              hit_ld_rs1;
    logic              hit_ld_rs2;
    logic              hit_ld;

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              mem_err_q;
    logic              mem_err_d;
    logic [CNT_W-1:0]  stall_count_q;
    logic [CNT_W-1:0]  stall_count_d;
    logic [CNT_W-1:0]  flush_count_q;
    logic [CNT_W-1:0]  flush_count_d;

    rv32i_fwd_mux #(
        .XLEN       (XLEN),
        .REG_W      (REG_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_rs1 (
        .rs_reg_i      (rs1_reg),
        .rs_used_i     (rs1_used),
        .rs_data_i     (rs1_data_in),
        .fwd_enable_i  (fwd_enable),
        .fwd_reg_i     (fwd_reg),
        .fwd_data_i    (fwd_data),
        .fwd_pending_i (fwd_pending),
        .rs_data_o     (rs1_data_out),
        .hit_ld_o      (hit_ld_rs1)
    );

    rv32i_fwd_mux #(
        .XLEN       (XLEN),
        .REG_W      (REG_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_rs2 (
        .rs_reg_i      (rs2_reg),
        .rs_used_i     (rs2_used),
        .rs_data_i     (rs2_data_in),
        .fwd_enable_i  (fwd_enable),
        .fwd_reg_i     (fwd_reg),
        .fwd_data_i    (fwd_data),
        .fwd_pending_i (fwd_pending),
        .rs_data_o     (rs2_data_out),
        .hit_ld_o      (hit_ld_rs2)
    );

    // A memory wait freezes the whole pipeline, so it masks the load-use
    // stall and any jump flush; a jump seen while stalled is re-presented.
    assign hit_ld    = hit_ld_rs1 | hit_ld_rs2;
    assign freeze    = mem_req & ~mem_ready;
    assign stall_id  = hit_ld & ~freeze;
    assign bubble_ex = hit_ld & ~freeze;
    assign flush_if  = jump_enable & ~stall_id & ~freeze;

    assign state       = state_q;
    assign mem_err     = mem_err_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // Next state is a pure function of this cycle's hazards.
    always_comb begin
        state_d = HZ_RUN;
        if (freeze) begin
            state_d = HZ_MEM_WAIT;
        end else if (hit_ld) begin
            state_d = HZ_LD_STALL;
        end
    end

    // Watchdog counts consecutive frozen cycles; the error latches on the
    // MEM_TIMEOUT-th one and the count parks there instead of wrapping.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (freeze) begin
            if (wait_cnt_q == WAIT_LAST) begin
                wait_cnt_d = wait_cnt_q;
                mem_err_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // Performance counters saturate at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((stall_id | freeze) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush_if && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // All registered state; reset may arrive at any time, including mid-wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HZ_RUN;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32i_hazard_unit
//   Self-checking bench for rv32i_hazard_unit. A default instance and a
//   CNT_W=4 instance share the same stimulus; a cycle-level reference model
//   tracks the expected outputs of both.
// ---------------------------------------------------------------------------
module tb_rv32i_hazard_unit;

    localparam int MEM_TIMEOUT = 16;

    typedef struct {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              u1;
        logic              u2;
        logic [31:0]       d1;
        logic [31:0]       d2;
        logic [2:0]        en;
        logic [2:0]        pend;
        logic [2:0][4:0]   regs;
        logic [2:0][31:0]  data;
        logic              jump;
        logic              req;
        logic              rdy;
        logic [31:0]       e1;
        logic [31:0]       e2;
        logic              eStall;
        logic              eFreeze;
        logic              eFlush;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1Reg, rs2Reg;
    logic        rs1Used, rs2Used;
    logic [31:0] rs1DataIn, rs2DataIn;
    logic [2:0]  fwdEnable, fwdPending;
    logic [4:0]  fReg[3];
    logic [31:0] fData[3];
    logic [14:0] fwdRegPacked;
    logic [95:0] fwdDataPacked;
    logic        jumpEnable, memReq, memReady;

    logic [31:0] rs1Out, rs2Out, stallCount, flushCount;
    logic        stallId, bubbleEx, freezeOut, flushIf, memErr;
    logic [1:0]  stateOut;

    logic [31:0] rs1OutSat, rs2OutSat;
    logic [3:0]  stallCountSat, flushCountSat;
    logic        stallIdSat, bubbleExSat, freezeSat, flushIfSat, memErrSat;
    logic [1:0]  stateSat;

    // model state
    logic [31:0] mRs1, mRs2;
    bit          mHit, mStall, mFreeze, mFlush;
    int          mState, mConsec, mStallSat, mFlushSat;
    bit          mErr;
    longint      mStallCnt, mFlushCnt;

    int compared = 0;
    int mismatched = 0;

    vec_t tbl[9];

    always #5 clk = ~clk;

    assign fwdRegPacked  = {fReg[2], fReg[1], fReg[0]};
    assign fwdDataPacked = {fData[2], fData[1], fData[0]};

    rv32i_hazard_unit #(.CNT_W(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .rs1_reg(rs1Reg), .rs2_reg(rs2Reg), .rs1_used(rs1Used), .rs2_used(rs2Used),
        .rs1_data_in(rs1DataIn), .rs2_data_in(rs2DataIn),
        .fwd_enable(fwdEnable), .fwd_reg(fwdRegPacked), .fwd_data(fwdDataPacked),
        .fwd_pending(fwdPending), .jump_enable(jumpEnable),
        .mem_req(memReq), .mem_ready(memReady),
        .rs1_data_out(rs1Out), .rs2_data_out(rs2Out),
        .stall_id(stallId), .bubble_ex(bubbleEx), .freeze(freezeOut), .flush_if(flushIf),
        .state(stateOut), .mem_err(memErr),
        .stall_count(stallCount), .flush_count(flushCount)
    );

    rv32i_hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dutSat (
        .clk(clk), .reset(reset),
        .rs1_reg(rs1Reg), .rs2_reg(rs2Reg), .rs1_used(rs1Used), .rs2_used(rs2Used),
        .rs1_data_in(rs1DataIn), .rs2_data_in(rs2DataIn),
        .fwd_enable(fwdEnable), .fwd_reg(fwdRegPacked), .fwd_data(fwdDataPacked),
        .fwd_pending(fwdPending), .jump_enable(jumpEnable),
        .mem_req(memReq), .mem_ready(memReady),
        .rs1_data_out(rs1OutSat), .rs2_data_out(rs2OutSat),
        .stall_id(stallIdSat), .bubble_ex(bubbleExSat), .freeze(freezeSat), .flush_if(flushIfSat),
        .state(stateSat), .mem_err(memErrSat),
        .stall_count(stallCountSat), .flush_count(flushCountSat)
    );

    // One comparison: counts it and reports a miss.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference forwarding for one operand: first enabled stage naming the
    // register, counting from the nearest; x0 is always zero.
    task automatic modelOperand(input logic [4:0] rs, input bit used, input logic [31:0] din,
                                output logic [31:0] dout, output bit hit);
        dout = din;
        hit  = 1'b0;
        if (rs == 5'd0) begin
            dout = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (fwdEnable[i] && fReg[i] == rs) begin
                dout = fData[i];
                hit  = used && fwdPending[i];
                return;
            end
        end
    endtask

    task automatic computeModel();
        bit h1, h2;
        modelOperand(rs1Reg, rs1Used, rs1DataIn, mRs1, h1);
        modelOperand(rs2Reg, rs2Used, rs2DataIn, mRs2, h2);
        mHit    = h1 || h2;
        mFreeze = memReq && !memReady;
        mStall  = mHit && !mFreeze;
        mFlush  = jumpEnable && !mStall && !mFreeze;
    endtask

    task automatic modelReset();
        mState = 0; mConsec = 0; mErr = 0;
        mStallCnt = 0; mFlushCnt = 0; mStallSat = 0; mFlushSat = 0;
    endtask

    // Compare every output of both instances against the model.
    task automatic checkOutput();
        #2;
        computeModel();
        checkVal("rs1_data_out", rs1Out, mRs1);
        checkVal("rs2_data_out", rs2Out, mRs2);
        checkVal("stall_id", 32'(stallId), 32'(mStall));
        checkVal("bubble_ex", 32'(bubbleEx), 32'(mStall));
        checkVal("freeze", 32'(freezeOut), 32'(mFreeze));
        checkVal("flush_if", 32'(flushIf), 32'(mFlush));
        checkVal("state", 32'(stateOut), 32'(mState));
        checkVal("mem_err", 32'(memErr), 32'(mErr));
        checkVal("stall_count", stallCount, 32'(mStallCnt));
        checkVal("flush_count", flushCount, 32'(mFlushCnt));
        checkVal("sat.stall_count", 32'(stallCountSat), 32'(mStallSat));
        checkVal("sat.flush_count", 32'(flushCountSat), 32'(mFlushSat));
        checkVal("sat.state", 32'(stateSat), 32'(mState));
    endtask

    // Advance one clock, updating the model's registered view.
    task automatic tick();
        computeModel();
        @(posedge clk);
        if (!reset) begin
            if (mFreeze) begin
                mConsec++;
                if (mConsec >= MEM_TIMEOUT) mErr = 1'b1;
            end else begin
                mConsec = 0;
            end
            if (mStall || mFreeze) begin
                mStallCnt++;
                if (mStallSat < 15) mStallSat++;
            end
            if (mFlush) begin
                mFlushCnt++;
                if (mFlushSat < 15) mFlushSat++;
            end
            mState = mFreeze ? 2 : (mHit ? 1 : 0);
        end
        #1;
    endtask

    task automatic clearInputs();
        rs1Reg = '0; rs2Reg = '0; rs1Used = 0; rs2Used = 0;
        rs1DataIn = '0; rs2DataIn = '0; fwdEnable = '0; fwdPending = '0;
        for (int i = 0; i < 3; i++) begin
            fReg[i] = '0;
            fData[i] = '0;
        end
        jumpEnable = 0; memReq = 0; memReady = 1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("rst.state", 32'(stateOut), 32'd0);
        checkVal("rst.mem_err", 32'(memErr), 32'd0);
        checkVal("rst.stall_count", stallCount, 32'd0);
        checkVal("rst.flush_count", flushCount, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rs1Reg = v.rs1; rs2Reg = v.rs2; rs1Used = v.u1; rs2Used = v.u2;
        rs1DataIn = v.d1; rs2DataIn = v.d2;
        fwdEnable = v.en; fwdPending = v.pend;
        for (int i = 0; i < 3; i++) begin
            fReg[i]  = v.regs[i];
            fData[i] = v.data[i];
        end
        jumpEnable = v.jump; memReq = v.req; memReady = v.rdy;
    endtask

    // Hazard on x3 from a pending load in stage 0.
    task automatic setLoadUse();
        clearInputs();
        fwdEnable = 3'b001; fReg[0] = 5'd3; fData[0] = 32'h33; fwdPending = 3'b001;
        rs1Reg = 5'd3; rs1Used = 1;
    endtask

    initial begin
        // field order: rs1 rs2 u1 u2 d1 d2 en pend regs{s2,s1,s0} data{s2,s1,s0} jump req rdy e1 e2 eStall eFreeze eFlush
        tbl[0] = '{5'd5, 5'd0, 1, 0, 32'h11, 32'h22, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0},
                   {32'h0, 32'h0, 32'h0}, 0, 0, 1, 32'h11, 32'h0, 0, 0, 0};
        tbl[1] = '{5'd5, 5'd7, 1, 1, 32'h11, 32'h22, 3'b101, 3'b000, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 0, 0, 1, 32'h11, 32'hA, 0, 0, 0};
        tbl[2] = '{5'd5, 5'd0, 1, 1, 32'h11, 32'h22, 3'b101, 3'b000, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 0, 0, 1, 32'h11, 32'h0, 0, 0, 0};
        tbl[3] = '{5'd5, 5'd7, 1, 1, 32'h11, 32'h22, 3'b100, 3'b000, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 0, 0, 1, 32'h11, 32'hC, 0, 0, 0};
        tbl[4] = '{5'd7, 5'd0, 1, 0, 32'h11, 32'h22, 3'b101, 3'b001, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 0, 0, 1, 32'hA, 32'h0, 1, 0, 0};
        tbl[5] = '{5'd7, 5'd0, 0, 0, 32'h11, 32'h22, 3'b101, 3'b001, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 0, 0, 1, 32'hA, 32'h0, 0, 0, 0};
        tbl[6] = '{5'd7, 5'd0, 1, 0, 32'h11, 32'h22, 3'b101, 3'b001, {5'd7, 5'd0, 5'd7},
                   {32'hC, 32'hB, 32'hA}, 1, 1, 0, 32'hA, 32'h0, 0, 1, 0};
        tbl[7] = '{5'd4, 5'd6, 1, 1, 32'h44, 32'h66, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0},
                   {32'h0, 32'h0, 32'h0}, 1, 0, 1, 32'h44, 32'h66, 0, 0, 1};
        tbl[8] = '{5'd1, 5'd7, 1, 1, 32'h11, 32'h22, 3'b011, 3'b010, {5'd0, 5'd7, 5'd3},
                   {32'hC, 32'hB, 32'hA}, 1, 0, 1, 32'h11, 32'hB, 1, 0, 0};

        clearInputs();
        reset = 1'b1;
        modelReset();
        #2;
        checkOutput();
        doReset();

        $display("[TB] table vectors");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(tbl[k]);
            #1;
            checkVal($sformatf("tbl%0d.rs1", k), rs1Out, tbl[k].e1);
            checkVal($sformatf("tbl%0d.rs2", k), rs2Out, tbl[k].e2);
            checkVal($sformatf("tbl%0d.stall", k), 32'(stallId), 32'(tbl[k].eStall));
            checkVal($sformatf("tbl%0d.bubble", k), 32'(bubbleEx), 32'(tbl[k].eStall));
            checkVal($sformatf("tbl%0d.freeze", k), 32'(freezeOut), 32'(tbl[k].eFreeze));
            checkVal($sformatf("tbl%0d.flush", k), 32'(flushIf), 32'(tbl[k].eFlush));
            checkOutput();
            tick();
        end

        $display("[TB] load-use sequence");
        clearInputs();
        doReset();
        setLoadUse();
        checkOutput();
        tick();
        checkVal("ld.state_stall", 32'(stateOut), 32'd1);
        checkVal("ld.stall_count", stallCount, 32'd1);
        fwdPending = 3'b000;
        checkOutput();
        tick();
        checkVal("ld.state_run", 32'(stateOut), 32'd0);

        $display("[TB] jump during stall");
        clearInputs();
        doReset();
        setLoadUse();
        jumpEnable = 1;
        checkOutput();
        checkVal("jmp.flush_blocked", 32'(flushIf), 32'd0);
        tick();
        clearInputs();
        jumpEnable = 1;
        checkOutput();
        checkVal("jmp.flush", 32'(flushIf), 32'd1);
        tick();
        checkVal("jmp.flush_count", flushCount, 32'd1);

        $display("[TB] memory wait and watchdog");
        clearInputs();
        doReset();
        memReq = 1; memReady = 0;
        for (int k = 1; k <= 18; k++) begin
            checkOutput();
            tick();
            if (k == 1)  checkVal("mw.state", 32'(stateOut), 32'd2);
            if (k == 15) checkVal("mw.err_early", 32'(memErr), 32'd0);
            if (k == 16) checkVal("mw.err_set", 32'(memErr), 32'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("mw.rst_state", 32'(stateOut), 32'd0);
        checkVal("mw.rst_err", 32'(memErr), 32'd0);
        checkVal("mw.rst_stall_count", stallCount, 32'd0);
        checkVal("mw.rst_freeze", 32'(freezeOut), 32'd1);
        clearInputs();
        tick();
        reset = 1'b0;
        checkOutput();

        $display("[TB] counter saturation");
        doReset();
        memReq = 1; memReady = 0;
        for (int k = 0; k < 20; k++) begin
            checkOutput();
            tick();
        end
        checkVal("sat.stall_count_15", 32'(stallCountSat), 32'd15);
        checkVal("wide.stall_count_20", stallCount, 32'd20);
        clearInputs();
        doReset();

        $display("[TB] random stimulus");
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                clearInputs();
                doReset();
            end
            rs1Reg = 5'($urandom_range(0, 7));
            rs2Reg = 5'($urandom_range(0, 7));
            rs1Used = 1'($urandom_range(0, 1));
            rs2Used = 1'($urandom_range(0, 1));
            rs1DataIn = $urandom;
            rs2DataIn = $urandom;
            fwdEnable = 3'($urandom_range(0, 7));
            fwdPending = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                fReg[i]  = 5'($urandom_range(0, 7));
                fData[i] = $urandom;
            end
            jumpEnable = 1'($urandom_range(0, 1));
            memReq = 1'($urandom_range(0, 1));
            memReady = ($urandom_range(0, 3) != 0);
            checkOutput();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
